// File: rtl/pipe_pkg.sv
// Shared widths and per-stage control/payload layouts for the pipeline stage registers.
package pipe_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned ALU_OP_W   = 8;
    localparam int unsigned ALU_OPT_W  = 5;
    localparam int unsigned WB_W       = 2;

    typedef struct packed {
        logic [ALU_OP_W-1:0]  alu_op;
        logic [ALU_OPT_W-1:0] alu_opt;
        logic                 mem_rd;
        logic                 mem_wr;
        logic [WB_W-1:0]      wb;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic            mem_rd;
        logic            mem_wr;
        logic [WB_W-1:0] wb;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [WB_W-1:0] wb;
    } mem_wb_ctrl_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WORD_W-1:0]     rs1_val;
        logic [WORD_W-1:0]     rs2_val;
        logic [WORD_W-1:0]     imm;
    } id_ex_data_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WORD_W-1:0]     alu_res;
        logic [WORD_W-1:0]     st_data;
    } ex_mem_data_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WORD_W-1:0]     result;
    } mem_wb_data_t;

    localparam int unsigned ID_EX_DATA_W  = $bits(id_ex_data_t);
    localparam int unsigned ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
    localparam int unsigned EX_MEM_DATA_W = $bits(ex_mem_data_t);
    localparam int unsigned EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int unsigned MEM_WB_DATA_W = $bits(mem_wb_data_t);
    localparam int unsigned MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

    // Where the main entry takes its next payload from.
    typedef enum logic {
        SRC_IN   = 1'b0,
        SRC_SKID = 1'b1
    } main_src_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid/data/ctrl storage entry. Clear drops valid and zeroes ctrl but keeps data.
module pipe_skid_entry #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clr_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush-to-bubble, optional skid entry
// and a saturating backpressure counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;

    logic              in_fire, out_fire, m_space;
    logic              m_load, m_clr;
    main_src_e         m_src;
    logic [DATA_W-1:0] m_ld_data;
    logic [CTRL_W-1:0] m_ld_ctrl;

    logic [CNT_W-1:0]  stall_q, stall_d;

    assign in_ready = (SKID != 0) ? ~s_valid : (out_ready | ~m_valid);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid & out_ready;
    assign m_space  = ~m_valid | out_fire;

    // One main-entry rule serves both modes: without a skid, s_valid is tied low
    // and an in_fire always implies m_space, so this reduces to the plain register.
    always_comb begin
        m_src     = s_valid ? SRC_SKID : SRC_IN;
        m_load    = m_space & (s_valid | in_fire);
        m_clr     = flush | (m_space & ~s_valid & ~in_fire);
        m_ld_data = in_data;
        m_ld_ctrl = in_ctrl;
        if (m_src == SRC_SKID) begin
            m_ld_data = s_data;
            m_ld_ctrl = s_ctrl;
        end
    end

    pipe_skid_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk_i   (clk),
        .rst_i   (reset),
        .clr_i   (m_clr),
        .load_i  (m_load),
        .data_i  (m_ld_data),
        .ctrl_i  (m_ld_ctrl),
        .valid_o (m_valid),
        .data_o  (m_data),
        .ctrl_o  (m_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic s_load, s_clr;

            // Skid only catches an accepted input the main entry cannot take.
            assign s_load = ~m_space & in_fire;
            assign s_clr  = flush | (m_space & s_valid);

            pipe_skid_entry #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk_i   (clk),
                .rst_i   (reset),
                .clr_i   (s_clr),
                .load_i  (s_load),
                .data_i  (in_data),
                .ctrl_i  (in_ctrl),
                .valid_o (s_valid),
                .data_o  (s_data),
                .ctrl_o  (s_ctrl)
            );
        end else begin : g_noskid
            assign s_valid = 1'b0;
            assign s_data  = '0;
            assign s_ctrl  = '0;
        end
    endgenerate

    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = '0;
        end else if (in_valid && !in_ready && !(&stall_q)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_ctrl;
    assign stall_cnt = stall_q;

endmodule
